if_stage: RTL

- Instruction-fetch stage, directly upstream of the decode stage.
- Holds the PC and fetches 32-bit words over a req/ack instruction-memory port.
- Presents instruction and PC to decode, honours decode's stall, and redirects on taken branches from execute.
- Has a one-entry buffer so a fetch that completes during a stall is not lost.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/if_buf.sv | 41 ++++
 rtl/if_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, bubble instruction and fetch-stage states.
package cpu_pkg;

  localparam int unsigned PC_W   = 16;
  localparam int unsigned INST_W = 32;
  localparam int unsigned OPC_W  = 7;

  localparam logic [OPC_W-1:0]  OPC_NOP  = 7'b0011110;
  localparam logic [INST_W-1:0] NOP_WORD = {OPC_NOP, 25'd0};

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_FULL  = 2'd1,
    S_DRAIN = 2'd2
  } if_state_t;

endpackage

// File: rtl/if_buf.sv
// One-entry instruction/PC holding register; flush wins over load, load over unload.
module if_buf
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_unload,
  input  logic              i_flush,
  input  logic [INST_W-1:0] i_inst,
  input  logic [PC_W-1:0]   i_pc,
  output logic              o_valid,
  output logic [INST_W-1:0] o_inst,
  output logic [PC_W-1:0]   o_pc
);

  logic              r_valid;
  logic [INST_W-1:0] r_inst;
  logic [PC_W-1:0]   r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_inst  <= i_inst;
      r_pc    <= i_pc;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc    = r_pc;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, req/ack memory port, stall buffering and branch redirect.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0]   P_RESET_PC = 16'h0000,
  parameter logic [PC_W-1:0]   P_PC_STEP  = 16'h0001,
  parameter logic [INST_W-1:0] P_NOP      = NOP_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              br_taken_i,
  input  logic [PC_W-1:0]   br_target_i,
  output logic              imem_req_o,
  output logic [PC_W-1:0]   imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_data_i,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   pc_value_o
);

  if_state_t         r_state;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_addr;
  logic              r_req;
  logic [INST_W-1:0] r_inst;
  logic [PC_W-1:0]   r_pc_value;

  logic              w_buf_load;
  logic              w_buf_unload;
  logic              w_buf_valid;
  logic [INST_W-1:0] w_buf_inst;
  logic [PC_W-1:0]   w_buf_pc;
  logic [PC_W-1:0]   w_pc_next;

  assign w_pc_next    = r_pc + P_PC_STEP;
  assign w_buf_load   = (r_state == S_FETCH) && r_req && imem_ack_i && stall_i && !br_taken_i;
  assign w_buf_unload = (r_state == S_FULL) && !stall_i && !br_taken_i;

  if_buf u_buf (
    .clk      (clk),
    .rst_n    (rst),
    .i_load   (w_buf_load),
    .i_unload (w_buf_unload),
    .i_flush  (br_taken_i),
    .i_inst   (imem_data_i),
    .i_pc     (r_pc),
    .o_valid  (w_buf_valid),
    .o_inst   (w_buf_inst),
    .o_pc     (w_buf_pc)
  );

  // req/addr are registered: each transition that starts a request preloads r_addr
  // with the address of the next fetch, so back-to-back acks sustain one word per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_FETCH;
      r_pc       <= P_RESET_PC;
      r_addr     <= P_RESET_PC;
      r_req      <= 1'b0;
      r_inst     <= P_NOP;
      r_pc_value <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_req) begin
            r_req <= 1'b1;
            if (br_taken_i) begin
              r_inst <= P_NOP;
              r_pc   <= br_target_i;
              r_addr <= br_target_i;
            end else begin
              r_addr <= r_pc;
            end
          end else if (br_taken_i) begin
            r_inst <= P_NOP;
            r_pc   <= br_target_i;
            if (imem_ack_i) r_addr  <= br_target_i;
            else            r_state <= S_DRAIN;
          end else if (imem_ack_i) begin
            r_pc <= w_pc_next;
            if (stall_i) begin
              r_req   <= 1'b0;
              r_state <= S_FULL;
            end else begin
              r_inst     <= imem_data_i;
              r_pc_value <= r_pc;
              r_addr     <= w_pc_next;
            end
          end else if (!stall_i) begin
            r_inst <= P_NOP;
          end
        end
        S_FULL: begin
          if (br_taken_i) begin
            r_inst  <= P_NOP;
            r_pc    <= br_target_i;
            r_addr  <= br_target_i;
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end else if (!stall_i && w_buf_valid) begin
            r_inst     <= w_buf_inst;
            r_pc_value <= w_buf_pc;
            r_addr     <= r_pc;
            r_req      <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (br_taken_i) begin
            r_inst <= P_NOP;
            r_pc   <= br_target_i;
          end
          if (imem_ack_i) begin
            r_state <= S_FETCH;
            r_addr  <= br_taken_i ? br_target_i : r_pc;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign imem_req_o  = r_req;
  assign imem_addr_o = r_addr;
  assign inst_o      = r_inst;
  assign pc_value_o  = r_pc_value;

endmodule
